dmem_responder: RTL and testbench

- Memory-side responder for the MEM-stage data port: accepts load/store requests driven by the pipeline and returns load data after a fixed, configurable number of wait states.
- Raises a stall to the hazard logic while a request is outstanding.
- Performs RV32I byte, halfword and word lane selection, sign/zero extension and byte-enable generation from funct3.
- Replaces the single-cycle data memory so that multi-cycle memory timing can be exercised.

---
 rtl/dmem_pkg.sv | 27 ++
 rtl/dmem_responder_if.sv | 27 ++
 rtl/dmem_lane_align.sv | 51 +++++
 rtl/dmem_responder.sv | 140 ++++++++++++++
 tb/tb_dmem_responder.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared constants, FSM encoding and funct3 decode for the data-memory responder.
package dmem_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned NUM_LANES = WORD_W / BYTE_W;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_e;

  // Unused funct3 codes fall back to word accesses.
  function automatic size_e f3_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_BYTE;
      F3_H, F3_HU: return SZ_HALF;
      default:     return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// MEM-stage data port: request from the pipeline, ready/stall/response back from memory.
interface dmem_responder_if;
  import dmem_pkg::*;

  logic              req_valid;
  logic              req_re;
  logic              req_we;
  logic [31:0]       req_addr;
  logic [2:0]        req_funct3;
  logic [WORD_W-1:0] req_wdata;
  logic              req_ready;
  logic              stall;
  logic              resp_valid;
  logic [WORD_W-1:0] resp_rdata;
  logic              err;

  modport master (
    output req_valid, req_re, req_we, req_addr, req_funct3, req_wdata,
    input  req_ready, stall, resp_valid, resp_rdata, err
  );

  modport slave (
    input  req_valid, req_re, req_we, req_addr, req_funct3, req_wdata,
    output req_ready, stall, resp_valid, resp_rdata, err
  );

endinterface

// File: rtl/dmem_lane_align.sv
// RV32I lane steering: byte enables, store-data replication, load extraction/extension and
// misalign detection. Halfword/word offsets are always force-aligned here.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]           funct3_i,
  input  logic [1:0]           addr_lo_i,
  input  logic [WORD_W-1:0]    wdata_i,
  input  logic [WORD_W-1:0]    rword_i,
  output logic [NUM_LANES-1:0] be_o,
  output logic [WORD_W-1:0]    wdata_o,
  output logic [WORD_W-1:0]    rdata_o,
  output logic                 misalign_o
);

  logic       sext;
  logic [7:0] rbyte;
  logic [15:0] rhalf;

  always_comb begin
    sext       = ~funct3_i[2];
    misalign_o = 1'b0;
    be_o       = '0;
    wdata_o    = '0;
    rdata_o    = '0;
    rbyte      = '0;
    rhalf      = '0;
    case (f3_size(funct3_i))
      SZ_BYTE: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rbyte   = rword_i[8*addr_lo_i +: 8];
        rdata_o = {{24{sext & rbyte[7]}}, rbyte};
      end
      SZ_HALF: begin
        misalign_o = addr_lo_i[0];
        be_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o    = {2{wdata_i[15:0]}};
        rhalf      = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
        rdata_o    = {{16{sext & rhalf[15]}}, rhalf};
      end
      default: begin
        misalign_o = |addr_lo_i;
        be_o       = '1;
        wdata_o    = wdata_i;
        rdata_o    = rword_i;
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder with stall generation. Define DMEM_MISALIGN_TRAP_EN to
// flag misaligned accesses via err (no write); otherwise they are force-aligned.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input logic             clk,
  input logic             reset,
  dmem_responder_if.slave bus
);

  localparam int unsigned AW      = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  CntLoad = 4'(LATENCY - 1);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [AW+1:0]       addr_q;
  logic [2:0]          funct3_q;
  logic [WORD_W-1:0]   wdata_q;
  logic                we_q, re_q;
  logic [WORD_W-1:0]   rdata_q;
  logic                err_q;
  logic [WORD_W-1:0]   mem [DEPTH_WORDS];

  logic                idle, accept, enter_resp, trap, misalign;
  logic [AW+1:0]       cur_addr;
  logic [2:0]          cur_funct3;
  logic [WORD_W-1:0]   cur_wdata;
  logic                cur_we, cur_re;
  logic [AW-1:0]       idx;
  logic [NUM_LANES-1:0] be;
  logic [WORD_W-1:0]   wdata_lane, rdata_ext;
  logic                unused_addr_hi;

  assign unused_addr_hi = ^bus.req_addr[31:AW+2];

  assign idle   = (state_q == S_IDLE);
  assign accept = idle & bus.req_valid & (bus.req_re | bus.req_we);

  // With LATENCY=1 the access happens on the acceptance edge, before the request is registered.
  assign cur_addr   = idle ? bus.req_addr[AW+1:0] : addr_q;
  assign cur_funct3 = idle ? bus.req_funct3 : funct3_q;
  assign cur_wdata  = idle ? bus.req_wdata : wdata_q;
  assign cur_we     = idle ? bus.req_we : we_q;
  assign cur_re     = idle ? bus.req_re : re_q;
  assign idx        = cur_addr[AW+1:2];

  dmem_lane_align u_lane_align (
    .funct3_i   (cur_funct3),
    .addr_lo_i  (cur_addr[1:0]),
    .wdata_i    (cur_wdata),
    .rword_i    (mem[idx]),
    .be_o       (be),
    .wdata_o    (wdata_lane),
    .rdata_o    (rdata_ext),
    .misalign_o (misalign)
  );

`ifdef DMEM_MISALIGN_TRAP_EN
  assign trap = misalign;
`else
  assign trap = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          cnt_d   = CntLoad;
          state_d = (LATENCY > 1) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign enter_resp = (state_d == S_RESP) && (state_q != S_RESP);

  always_comb begin
    bus.req_ready  = idle;
    bus.stall      = accept | (state_q == S_WAIT);
    bus.resp_valid = (state_q == S_RESP);
    bus.resp_rdata = (state_q == S_RESP) ? rdata_q : '0;
    bus.err        = (state_q == S_RESP) ? err_q : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q   <= '0;
      funct3_q <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      re_q     <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        addr_q   <= bus.req_addr[AW+1:0];
        funct3_q <= bus.req_funct3;
        wdata_q  <= bus.req_wdata;
        we_q     <= bus.req_we;
        re_q     <= bus.req_re;
      end
      if (enter_resp) begin
        // Stores (including re&we) and trapped accesses return zero data.
        rdata_q <= (cur_re && !cur_we && !trap) ? rdata_ext : '0;
        err_q   <= trap;
      end
    end
  end

  // Array is not reset; a reset on the commit edge drops the pending write.
  always_ff @(posedge clk) begin
    if (!reset && enter_resp && cur_we && !trap) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (be[i]) mem[idx][i*BYTE_W +: BYTE_W] <= wdata_lane[i*BYTE_W +: BYTE_W];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed table-driven bench for dmem_responder (LATENCY=2 and LATENCY=1 instances).
module tb_dmem_responder;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        v0, v1, re, we;
  logic [31:0] addr, wdata;
  logic [2:0]  f3;

  dmem_responder_if bus0 ();
  dmem_responder_if bus1 ();

  assign bus0.req_valid  = v0;
  assign bus0.req_re     = re;
  assign bus0.req_we     = we;
  assign bus0.req_addr   = addr;
  assign bus0.req_funct3 = f3;
  assign bus0.req_wdata  = wdata;
  assign bus1.req_valid  = v1;
  assign bus1.req_re     = re;
  assign bus1.req_we     = we;
  assign bus1.req_addr   = addr;
  assign bus1.req_funct3 = f3;
  assign bus1.req_wdata  = wdata;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  typedef struct {
    logic        re;
    logic        we;
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t tv[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input logic r, input logic w, input logic [31:0] a,
                              input logic [2:0] f, input logic [31:0] d,
                              input logic [31:0] er, input logic ee);
    vec_t v;
    v.re = r; v.we = w; v.addr = a; v.f3 = f; v.wdata = d; v.exp_rdata = er; v.exp_err = ee;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Presents one request (called just after a rising edge), holds it until resp_valid.
  task automatic access(input bit sel, input logic r, input logic w, input logic [31:0] a,
                        input logic [2:0] f, input logic [31:0] d, output logic [31:0] rd,
                        output logic e, output int stalls, output int lat);
    re = r; we = w; addr = a; f3 = f; wdata = d;
    if (sel) v1 = 1'b1;
    else     v0 = 1'b1;
    stalls = 0; lat = -1; rd = 'x; e = 1'bx;
    for (int c = 0; c < 20 && lat < 0; c++) begin
      @(negedge clk);
      if (sel ? bus1.stall : bus0.stall) stalls++;
      if (sel ? bus1.resp_valid : bus0.resp_valid) begin
        lat = c;
        rd  = sel ? bus1.resp_rdata : bus0.resp_rdata;
        e   = sel ? bus1.err : bus0.err;
      end
      @(posedge clk); #1;
    end
    v0 = 1'b0; v1 = 1'b0;
  endtask

  task automatic run_table(input string tag);
    logic [31:0] rd;
    logic        e;
    int          st, lat;
    for (int i = 0; i < tv.size(); i++) begin
      access(1'b0, tv[i].re, tv[i].we, tv[i].addr, tv[i].f3, tv[i].wdata, rd, e, st, lat);
      check($sformatf("%s[%0d] rdata", tag, i), rd, tv[i].exp_rdata);
      check($sformatf("%s[%0d] err", tag, i), 32'(e), 32'(tv[i].exp_err));
      check($sformatf("%s[%0d] latency", tag, i), 32'(lat), 32'd2);
      check($sformatf("%s[%0d] stall cycles", tag, i), 32'(st), 32'd2);
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic        e;
    int          st, lat;

    reset = 1'b1; v0 = 1'b0; v1 = 1'b0; re = 1'b0; we = 1'b0;
    addr = '0; wdata = '0; f3 = F3_W;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset req_ready", 32'(bus0.req_ready), 32'd1);
    check("reset stall", 32'(bus0.stall), 32'd0);
    check("reset resp_valid", 32'(bus0.resp_valid), 32'd0);
    check("reset resp_rdata", bus0.resp_rdata, 32'd0);
    check("reset err", 32'(bus0.err), 32'd0);
    check("reset req_ready lat1", 32'(bus1.req_ready), 32'd1);
    @(posedge clk); #1;

    // Stores, loads, lane extraction, sub-word stores, odd funct3 and re&we together.
    tv.push_back(mk(0, 1, 32'h10, F3_W,   32'hDEADBEEF, 32'h0,        0));
    tv.push_back(mk(1, 0, 32'h10, F3_W,   32'h0,        32'hDEADBEEF, 0));
    tv.push_back(mk(1, 0, 32'h13, F3_B,   32'h0,        32'hFFFFFFDE, 0));
    tv.push_back(mk(1, 0, 32'h13, F3_BU,  32'h0,        32'h000000DE, 0));
    tv.push_back(mk(1, 0, 32'h10, F3_H,   32'h0,        32'hFFFFBEEF, 0));
    tv.push_back(mk(1, 0, 32'h12, F3_HU,  32'h0,        32'h0000DEAD, 0));
    tv.push_back(mk(0, 1, 32'h11, F3_B,   32'h55,       32'h0,        0));
    tv.push_back(mk(1, 0, 32'h10, F3_W,   32'h0,        32'hDEAD55EF, 0));
    tv.push_back(mk(0, 1, 32'h14, F3_W,   32'h0,        32'h0,        0));
    tv.push_back(mk(0, 1, 32'h16, F3_H,   32'h8001,     32'h0,        0));
    tv.push_back(mk(1, 0, 32'h14, F3_W,   32'h0,        32'h80010000, 0));
    tv.push_back(mk(1, 0, 32'h16, F3_H,   32'h0,        32'hFFFF8001, 0));
    tv.push_back(mk(1, 0, 32'h17, F3_B,   32'h0,        32'hFFFFFF80, 0));
    tv.push_back(mk(1, 0, 32'h16, F3_BU,  32'h0,        32'h00000001, 0));
    tv.push_back(mk(1, 0, 32'h10, 3'b011, 32'h0,        32'hDEAD55EF, 0));
    tv.push_back(mk(1, 1, 32'h18, F3_W,   32'hCAFEF00D, 32'h0,        0));
    tv.push_back(mk(1, 0, 32'h18, F3_W,   32'h0,        32'hCAFEF00D, 0));
    tv.push_back(mk(0, 1, 32'h20, F3_W,   32'h11111111, 32'h0,        0));
    run_table("main");

    // Reset during the WAIT cycle of a store drops the write and the response.
    re = 1'b0; we = 1'b1; addr = 32'h20; wdata = 32'h12345678; f3 = F3_W; v0 = 1'b1;
    @(negedge clk);
    check("rst-mid accept stall", 32'(bus0.stall), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1; v0 = 1'b0;
    @(negedge clk);
    check("rst-mid wait req_ready", 32'(bus0.req_ready), 32'd0);
    check("rst-mid wait resp_valid", 32'(bus0.resp_valid), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst-mid after stall", 32'(bus0.stall), 32'd0);
    check("rst-mid after resp_valid", 32'(bus0.resp_valid), 32'd0);
    check("rst-mid after req_ready", 32'(bus0.req_ready), 32'd1);
    @(posedge clk); #1;
    access(1'b0, 1'b1, 1'b0, 32'h20, F3_W, 32'h0, rd, e, st, lat);
    check("rst-mid old data kept", rd, 32'h11111111);

    // Misaligned accesses.
    tv.delete();
`ifdef DMEM_MISALIGN_TRAP_EN
    tv.push_back(mk(1, 0, 32'h22, F3_W,  32'h0,    32'h0,        1));
    tv.push_back(mk(0, 1, 32'h21, F3_H,  32'hBEEF, 32'h0,        1));
    tv.push_back(mk(1, 0, 32'h20, F3_W,  32'h0,    32'h11111111, 0));
    tv.push_back(mk(1, 0, 32'h13, F3_HU, 32'h0,    32'h0,        1));
`else
    tv.push_back(mk(1, 0, 32'h22, F3_W,  32'h0,    32'h11111111, 0));
    tv.push_back(mk(0, 1, 32'h21, F3_H,  32'hBEEF, 32'h0,        0));
    tv.push_back(mk(1, 0, 32'h20, F3_W,  32'h0,    32'h1111BEEF, 0));
    tv.push_back(mk(1, 0, 32'h13, F3_HU, 32'h0,    32'h0000DEAD, 0));
`endif
    run_table("misalign");

    // LATENCY=1: valid without re/we is ignored; upper address bits wrap.
    re = 1'b0; we = 1'b0; addr = 32'h10; f3 = F3_W; v1 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("nop stall c%0d", c), 32'(bus1.stall), 32'd0);
      check($sformatf("nop resp_valid c%0d", c), 32'(bus1.resp_valid), 32'd0);
      @(posedge clk); #1;
    end
    v1 = 1'b0;
    access(1'b1, 1'b0, 1'b1, 32'h10, F3_W, 32'hA5A5A5A5, rd, e, st, lat);
    check("lat1 store latency", 32'(lat), 32'd1);
    check("lat1 store stall cycles", 32'(st), 32'd1);
    check("lat1 store rdata", rd, 32'h0);
    access(1'b1, 1'b1, 1'b0, 32'h410, F3_W, 32'h0, rd, e, st, lat);
    check("lat1 wrap load rdata", rd, 32'hA5A5A5A5);
    check("lat1 wrap load latency", 32'(lat), 32'd1);
    check("lat1 wrap load err", 32'(e), 32'd0);
    access(1'b1, 1'b1, 1'b0, 32'h413, F3_B, 32'h0, rd, e, st, lat);
    check("lat1 wrap LB rdata", rd, 32'hFFFFFFA5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
